// File: rtl/mpc_rd_engine.sv
// mpc_rd_engine: issues sequential SRAM port-B reads per command and streams the words
// through a 2-entry credit-managed buffer with last/done signalling.
module mpc_rd_engine #(
  parameter int DWIDTH    = 32,
  parameter int NRAMWIDHT = 5,
  parameter int AWIDTH    = 13,
  parameter int LWIDTH    = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic [NRAMWIDHT+AWIDTH-1:0] cmd_addr_in,
  input  logic [LWIDTH-1:0]           cmd_len_in,
  output logic                        sram_en_out,
  output logic                        sram_we_out,
  output logic [NRAMWIDHT+AWIDTH-1:0] sram_addr_out,
  input  logic [DWIDTH-1:0]           sram_d_in,
  output logic                        rd_valid_out,
  input  logic                        rd_ready_in,
  output logic [DWIDTH-1:0]           rd_data_out,
  output logic                        rd_last_out,
  output logic                        done_out,
  output logic                        busy_out
);
  localparam int AW = NRAMWIDHT + AWIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] next_addr, addr_hold;
  logic [LWIDTH-1:0] remaining;
  logic inflight, inflight_last, zero_done;
  logic [DWIDTH-1:0] buf_data [2];
  logic [1:0] buf_last;
  logic wr_ptr, rd_ptr;
  logic [1:0] occ;
  logic accept, issue, pop, final_issue;
  assign cmd_ready_out = state == IDLE;
  assign busy_out      = state != IDLE;
  assign rd_valid_out  = occ != 2'd0;
  assign rd_data_out   = buf_data[rd_ptr];
  assign rd_last_out   = buf_last[rd_ptr];
  assign sram_en_out   = issue;
  assign sram_we_out   = 1'b0;
  assign sram_addr_out = issue ? next_addr : addr_hold;
  assign done_out      = zero_done | (state == DRAIN & pop & rd_last_out);
  // A pop in the same cycle frees a credit, so issue keeps full rate under steady ready.
  always_comb begin
    accept      = cmd_valid_in & cmd_ready_out;
    pop         = rd_valid_out & rd_ready_in;
    issue       = state == ISSUE && ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    final_issue = issue && remaining == LWIDTH'(1);
    state_nxt   = (accept && cmd_len_in != '0) ? ISSUE :
                  final_issue                  ? DRAIN :
                  (state == DRAIN && pop && rd_last_out) ? IDLE : state;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      next_addr     <= '0;
      addr_hold     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= final_issue;
      zero_done     <= accept && cmd_len_in == '0;
      if (accept) begin
        next_addr <= cmd_addr_in;
        remaining <= cmd_len_in;
      end else if (issue) begin
        next_addr <= next_addr + AW'(1);
        remaining <= remaining - LWIDTH'(1);
      end
      if (issue) addr_hold <= next_addr;
    end
  end
  // Read data returns one cycle after issue; capture it tagged with its last flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= '0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= sram_d_in;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_mpc_rd_engine.sv
// tb_mpc_rd_engine: randomized and directed bench with a word-stream scoreboard model.
module tb_mpc_rd_engine;
  localparam int DW = 32, AW = 18, LW = 8;
  logic clk_in = 0, rst_n_in = 0, cmd_valid_in = 0, rd_ready_in = 1;
  logic [AW-1:0] cmd_addr_in = '0;
  logic [LW-1:0] cmd_len_in = '0;
  logic [DW-1:0] sram_d_in = '0;
  logic cmd_ready_out, sram_en_out, sram_we_out, rd_valid_out, rd_last_out, done_out, busy_out;
  logic [AW-1:0] sram_addr_out;
  logic [DW-1:0] rd_data_out;
  int total = 0, bad = 0, cyc = 0;
  int rdy_mode = 0;
  logic [AW-1:0] addr_q [$];
  logic [DW:0] word_q [$];
  int acc_q [$];
  int outst = 0, done_cnt = 0, acc_cnt = 0, en_cnt = 0, pop_cnt = 0, fv = -1, done_cyc = -1;
  bit zero_pend = 0, pop_s = 0, lastpop = 0, prev_hold = 0;
  logic [DW:0] prev_w, exp_w;

  mpc_rd_engine #(.DWIDTH(DW), .NRAMWIDHT(5), .AWIDTH(13), .LWIDTH(LW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_addr_in(cmd_addr_in), .cmd_len_in(cmd_len_in), .sram_en_out(sram_en_out),
    .sram_we_out(sram_we_out), .sram_addr_out(sram_addr_out), .sram_d_in(sram_d_in),
    .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in), .rd_data_out(rd_data_out),
    .rd_last_out(rd_last_out), .done_out(done_out), .busy_out(busy_out));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a[7:0], 6'h15, a} ^ 32'hC3A5_0000;
  endfunction

  // SRAM port B: one-cycle read latency; garbage on non-read cycles must be ignored
  always @(posedge clk_in) sram_d_in <= sram_en_out ? word_of(sram_addr_out) : $urandom;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    #1;
    rd_ready_in = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~rd_ready_in :
                  rdy_mode == 2 ? 1'($urandom) : 1'b0;
  end

  initial forever begin
    @(negedge clk_in);
    if (!rst_n_in) begin
      addr_q.delete();
      word_q.delete();
      outst = 0;
      zero_pend = 0;
      prev_hold = 0;
    end else begin
      pop_s   = rd_valid_out && rd_ready_in;
      lastpop = pop_s && rd_last_out;
      chk("done", done_out, zero_pend || lastpop);
      zero_pend = 0;
      if (done_out) begin done_cnt++; done_cyc = cyc; end
      if (rd_valid_out && fv < 0) fv = cyc;
      if (prev_hold) chk("hold", {rd_last_out, rd_data_out}, prev_w);
      prev_hold = rd_valid_out && !rd_ready_in;
      prev_w = {rd_last_out, rd_data_out};
      if (sram_en_out) begin
        en_cnt++;
        outst++;
        chk("en_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("sram_addr", sram_addr_out, addr_q.pop_front());
        chk("we", sram_we_out, 0);
      end
      if (pop_s) begin
        pop_cnt++;
        outst--;
        chk("word_expected", word_q.size() != 0, 1);
        if (word_q.size() != 0) begin
          exp_w = word_q.pop_front();
          chk("rd_data", rd_data_out, exp_w[DW-1:0]);
          chk("rd_last", rd_last_out, exp_w[DW]);
        end
      end
      if (sram_en_out) chk("credit", outst <= 2, 1);
      if (cmd_valid_in && cmd_ready_out) begin
        acc_q.push_back(cyc);
        acc_cnt++;
        fv = -1;
        if (cmd_len_in == 0) zero_pend = 1;
        for (int i = 0; i < int'(cmd_len_in); i++) begin
          addr_q.push_back(cmd_addr_in + AW'(i));
          word_q.push_back({i == int'(cmd_len_in) - 1, word_of(cmd_addr_in + AW'(i))});
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input int n);
    int t = 0;
    cmd_addr_in = a;
    cmd_len_in = LW'(n);
    cmd_valid_in = 1;
    do begin @(negedge clk_in); t++; end while (!cmd_ready_out && t < 500);
    if (t >= 500) chk("accept_timeout", cmd_ready_out, 1);
    @(posedge clk_in);
    #1;
    cmd_valid_in = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk_in);
    while ((busy_out || word_q.size() != 0) && t < 3000) begin @(negedge clk_in); t++; end
    chk("idle", busy_out, 0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, cmd_ready_out, 1);
    chk({tag, "_en"}, sram_en_out, 0);
    chk({tag, "_we"}, sram_we_out, 0);
    chk({tag, "_addr"}, sram_addr_out, 0);
    chk({tag, "_valid"}, rd_valid_out, 0);
    chk({tag, "_data"}, rd_data_out, 0);
    chk({tag, "_last"}, rd_last_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
  endtask

  initial begin
    int e0, p0, d0, a0, t;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset("rst");
    @(negedge clk_in);
    rst_n_in = 1;
    @(posedge clk_in);
    #1;
    // basic read, ready held high
    send(18'h00010, 4);
    wait_idle();
    chk("t1_first_valid", fv - acc_q[$], 3);
    chk("t1_done_lat", done_cyc - acc_q[$], 6);
    // address wrap across the top of the space
    send(18'h3FFFE, 4);
    wait_idle();
    chk("t2_done_lat", done_cyc - acc_q[$], 6);
    // toggling ready with a long low stretch
    rdy_mode = 1;
    p0 = pop_cnt;
    send(18'h01234, 16);
    repeat (3) @(negedge clk_in);
    rdy_mode = 3;
    repeat (4) @(negedge clk_in);
    e0 = en_cnt;
    repeat (7) @(negedge clk_in);
    chk("stall_en", en_cnt - e0, 0);
    rdy_mode = 1;
    wait_idle();
    chk("t3_words", pop_cnt - p0, 16);
    // zero-length command
    rdy_mode = 0;
    e0 = en_cnt;
    p0 = pop_cnt;
    d0 = done_cnt;
    send(18'h00055, 0);
    chk("z_ready", cmd_ready_out, 1);
    wait_idle();
    chk("z_en", en_cnt - e0, 0);
    chk("z_words", pop_cnt - p0, 0);
    chk("z_done_cnt", done_cnt - d0, 1);
    chk("z_done_lat", done_cyc - acc_q[$], 1);
    // back-to-back commands
    p0 = pop_cnt;
    d0 = done_cnt;
    send(18'h00100, 3);
    send(18'h00200, 5);
    wait_idle();
    chk("b2b_gap", acc_q[$] - acc_q[$-1], 6);
    chk("b2b_words", pop_cnt - p0, 8);
    chk("b2b_done", done_cnt - d0, 2);
    // reset mid-command
    p0 = pop_cnt;
    send(18'h02000, 8);
    t = 0;
    while (pop_cnt - p0 < 3 && t < 100) begin @(negedge clk_in); t++; end
    chk("pre_rst_words", pop_cnt - p0 >= 3, 1);
    #2;
    rst_n_in = 0;
    #1;
    chk_reset("mid_rst");
    @(negedge clk_in);
    rst_n_in = 1;
    @(posedge clk_in);
    #1;
    p0 = pop_cnt;
    send(18'h00040, 2);
    wait_idle();
    chk("post_rst_words", pop_cnt - p0, 2);
    // randomized commands and backpressure
    d0 = done_cnt;
    a0 = acc_cnt;
    p0 = pop_cnt;
    e0 = 0;
    for (int k = 0; k < 30; k++) begin
      int n;
      rdy_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 20);
      e0 += n;
      send(AW'($urandom), n);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    rdy_mode = 0;
    wait_idle();
    chk("rand_done", done_cnt - d0, acc_cnt - a0);
    chk("rand_words", pop_cnt - p0, e0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mpc_rd_engine.md
# mpc_rd_engine

Read-side stage that sits directly downstream of the multi-bank SRAM array and drives its port B. Accepts a read command (start address, word count), issues one sequential SRAM read per cycle, absorbs the fixed 1-cycle SRAM read latency, and presents the words as a valid/ready stream with a last flag. A 2-entry output buffer with credit-based issue makes backpressure lossless at full throughput.

## Interface
- DWIDTH, 32, data word width; must match the SRAM array
- NRAMWIDHT, 5, bank-select bits of the SRAM address
- AWIDTH, 13, in-bank address bits
- LWIDTH, 8, width of the command word count
- clk_in  input  1  single clock, also drives SRAM port B clock
- rst_n_in  input  1  reset, asynchronous, active-low
- cmd_valid_in  input  1  command offered
- cmd_ready_out  output  1  command accepted when high with cmd_valid_in
- cmd_addr_in  input  NRAMWIDHT+AWIDTH  first word address
- cmd_len_in  input  LWIDTH  word count; 0 is legal
- sram_en_out  output  1  SRAM port B enable
- sram_we_out  output  1  SRAM port B write enable, constant 0
- sram_addr_out  output  NRAMWIDHT+AWIDTH  SRAM port B address
- sram_d_in  input  DWIDTH  SRAM port B read data
- rd_valid_out  output  1  output word valid
- rd_ready_in  input  1  downstream ready
- rd_data_out  output  DWIDTH  output word
- rd_last_out  output  1  marks final word of the command
- done_out  output  1  one-cycle pulse at command completion
- busy_out  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, DRAIN. cmd_ready_out = (state==IDLE).
- IDLE: on cmd_valid_in&cmd_ready_out latch addr/len. len!=0 -> ISSUE with remaining=len, next_addr=cmd_addr_in. len==0 -> stay IDLE, no SRAM access, done_out pulses next cycle.
- ISSUE: issue when occ + inflight - pop < 2 (occ = buffer entries 0..2, inflight = read issued last cycle 0/1, pop = rd_valid_out&rd_ready_in). Issue cycle: sram_en_out=1, sram_addr_out=next_addr; next_addr += 1 modulo 2^(NRAMWIDHT+AWIDTH) (wraps from all-ones to 0, crossing banks freely); remaining -= 1. Issuing the final word -> DRAIN.
- Non-issue cycles: sram_en_out=0, sram_addr_out holds last value.
- Capture: one cycle after an issue, sram_d_in is written into the buffer with last flag = (that issue was the final word). sram_d_in ignored otherwise.
- Buffer: 2-entry FIFO, head drives rd_data_out/rd_last_out; rd_valid_out = occ!=0. Simultaneous push and pop permitted at any occupancy; overflow impossible by the credit rule.
- DRAIN: when the last-flagged word pops -> IDLE; done_out pulses that same cycle.
- rd_data_out, rd_last_out hold stable while rd_valid_out&!rd_ready_in.

## Timing
- Reset (async assert, sync release): state=IDLE, cmd_ready_out=1, sram_en_out=0, sram_we_out=0, sram_addr_out=0, rd_valid_out=0, rd_data_out=0, rd_last_out=0, done_out=0, busy_out=0; buffer, inflight, counters cleared. Reset mid-command discards all pending and buffered words.
- Command accepted cycle T -> first sram_en_out in T+1 -> data on sram_d_in T+2 -> rd_valid_out from T+3.
- rd_ready_in held high: one word per cycle, N words on T+3..T+N+2, done_out at T+N+2, cmd_ready_out high T+N+3; next command accepted earliest T+N+3.
- rd_ready_in low: at most 2 words buffered, issue stalls; resumes in the cycle ready returns (pop frees a credit same cycle).
- Word count max 2^LWIDTH-1; no partial-command abort.

## Test plan
- cmd addr=0x00010, len=4, ready=1 -> SRAM reads 0x00010..0x00013 on T+1..T+4; words out T+3..T+6, last with 4th, done_out at T+6.
- addr=0x3FFFE (all-ones minus 1, 18-bit), len=4 -> sram_addr_out 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; data in order.
- len=16, rd_ready_in toggling 1/0 every cycle plus a 10-cycle low stretch -> no lost/duplicated words, never >2 outstanding, sram_en_out low while stalled.
- len=0 -> no sram_en_out, no rd_valid_out, done_out pulse at T+1, cmd_ready_out stays 1.
- Back-to-back commands len=3 then len=5 with cmd_valid_in held -> second accepted at T+6, 8 words total, two last flags, two done pulses.
- rst_n_in asserted during command 8 words, 3 delivered -> all outputs to reset values immediately; post-reset command len=2 completes normally.
